// File: rtl/phy_clk_gate_ctrl.sv
// Enable sequencer for one phy_clk_gate shared by NUM_REQ requesters: OFF -> WAKE -> ON -> DRAIN.
// Optional build macro PHY_CLK_GATE_CTRL_STATS_EN adds a saturating gate_off_cnt output.
module phy_clk_gate_ctrl #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 8,
  parameter int WAKE_CYC  = 2,
  parameter int DRAIN_CYC = 2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  input  logic [CNT_W-1:0]   idle_thresh,
  output logic               clk_en,
  output logic [NUM_REQ-1:0] ack,
  output logic [1:0]         gate_state
`ifdef PHY_CLK_GATE_CTRL_STATS_EN
  ,
  output logic [15:0]        gate_off_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } gate_state_t;

  localparam logic [3:0] WAKE_LAST  = 4'(WAKE_CYC - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  gate_state_t      state;
  logic [3:0]       wake_cnt;
  logic [3:0]       drain_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             demand;
  logic             drain_done;

  assign demand     = (|req) | force_on;
  assign drain_done = (state == ST_DRAIN) && !demand && (drain_cnt == DRAIN_LAST);
  assign gate_state = state;

  // The gate enable is held high through WAKE, ON and DRAIN; it only falls on the DRAIN->OFF edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      clk_en    <= 1'b0;
      ack       <= '0;
      wake_cnt  <= '0;
      drain_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          ack       <= '0;
          wake_cnt  <= '0;
          drain_cnt <= '0;
          idle_cnt  <= '0;
          if (demand) begin
            state  <= ST_WAKE;
            clk_en <= 1'b1;
          end
        end
        ST_WAKE: begin
          ack <= '0;
          if (wake_cnt == WAKE_LAST) begin
            state    <= ST_ON;
            wake_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 4'd1;
          end
        end
        ST_ON: begin
          ack       <= req;
          drain_cnt <= '0;
          if (demand) begin
            idle_cnt <= '0;
          end else if (idle_cnt == idle_thresh) begin
            state <= ST_DRAIN;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          ack <= '0;
          if (demand) begin
            state     <= ST_ON;
            drain_cnt <= '0;
            idle_cnt  <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state     <= ST_OFF;
            clk_en    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: begin
          state  <= ST_OFF;
          clk_en <= 1'b0;
          ack    <= '0;
        end
      endcase
    end
  end

`ifdef PHY_CLK_GATE_CTRL_STATS_EN
  // Counts completed gate closures, sticking at all-ones.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_off_cnt <= '0;
    end else if (drain_done && (gate_off_cnt != 16'hFFFF)) begin
      gate_off_cnt <= gate_off_cnt + 16'd1;
    end
  end
`else
  logic unused_drain_done;
  assign unused_drain_done = drain_done;
`endif

endmodule

// File: tb/tb_phy_clk_gate_ctrl.sv
// Randomized self-checking bench for phy_clk_gate_ctrl against a cycle-indexed behavioural model.
// Build with PHY_CLK_GATE_CTRL_STATS_EN to also check gate_off_cnt.
module tb_phy_clk_gate_ctrl;

  localparam int NUM_REQ   = 4;
  localparam int CNT_W     = 8;
  localparam int WAKE_CYC  = 2;
  localparam int DRAIN_CYC = 2;

  logic               clk_in = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic               force_on = 1'b0;
  logic [CNT_W-1:0]   idle_thresh = 8'd3;
  logic               clk_en;
  logic [NUM_REQ-1:0] ack;
  logic [1:0]         gate_state;
`ifdef PHY_CLK_GATE_CTRL_STATS_EN
  logic [15:0]        gate_off_cnt;
`endif

  always #5 clk_in = ~clk_in;

  phy_clk_gate_ctrl #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .WAKE_CYC(WAKE_CYC), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .req(req),
    .force_on(force_on),
    .idle_thresh(idle_thresh),
    .clk_en(clk_en),
    .ack(ack),
    .gate_state(gate_state)
`ifdef PHY_CLK_GATE_CTRL_STATS_EN
    ,
    .gate_off_cnt(gate_off_cnt)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Model: the gate is described by when it opened, how long it has been idle and when draining began.
  bit                 m_open;
  int                 m_opened_at;
  int                 m_idle_run;
  int                 m_drain_at;
  int                 cyc;
  logic [NUM_REQ-1:0] m_ack;
  int                 m_off_count;

  function automatic int modelPhase();
    if (!m_open) return 0;
    if (m_drain_at >= 0) return 3;
    if (cyc < m_opened_at + WAKE_CYC) return 1;
    return 2;
  endfunction

  task automatic modelReset();
    m_open = 0; m_opened_at = 0; m_idle_run = 0; m_drain_at = -1;
    cyc = 0; m_ack = '0; m_off_count = 0;
  endtask

  task automatic modelEdge(input logic [NUM_REQ-1:0] r, input logic f, input int th);
    bit dem;
    int ph;
    logic [NUM_REQ-1:0] n_ack;
    dem = (r != 0) || f;
    ph = modelPhase();
    n_ack = '0;
    case (ph)
      0: if (dem) begin m_open = 1; m_opened_at = cyc + 1; end
      1: if (cyc + 1 >= m_opened_at + WAKE_CYC) m_idle_run = 0;
      2: begin
        n_ack = r;
        if (dem) m_idle_run = 0;
        else if (m_idle_run == th) m_drain_at = cyc + 1;
        else if (m_idle_run < (1 << CNT_W) - 1) m_idle_run++;
      end
      default: begin
        if (dem) begin
          m_drain_at = -1; m_idle_run = 0;
        end else if (cyc + 1 - m_drain_at >= DRAIN_CYC) begin
          m_open = 0; m_drain_at = -1;
          if (m_off_count < 65535) m_off_count++;
        end
      end
    endcase
    m_ack = n_ack;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, compare at the falling edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic f);
    int th;
    req = r;
    force_on = f;
    th = int'(idle_thresh);
    @(posedge clk_in);
    modelEdge(r, f, th);
    @(negedge clk_in);
    checkOutput("clk_en", 32'(clk_en), 32'(m_open));
    checkOutput("ack", 32'(ack), 32'(m_ack));
    checkOutput("gate_state", 32'(gate_state), 32'(modelPhase()));
`ifdef PHY_CLK_GATE_CTRL_STATS_EN
    checkOutput("gate_off_cnt", 32'(gate_off_cnt), 32'(m_off_count));
`endif
  endtask

  task automatic asyncReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
    checkOutput({tag, "_state"}, 32'(gate_state), 32'd0);
    req = '0;
    force_on = 1'b0;
    modelReset();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NUM_REQ-1:0] rnd_req;
    logic               rnd_force;
    modelReset();
    repeat (3) @(negedge clk_in);
    checkOutput("rst_clk_en", 32'(clk_en), 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_state", 32'(gate_state), 32'd0);
    rst_n = 1'b1;

    repeat (20) applyStimulus('0, 1'b0);
    checkOutput("idle_hold_state", 32'(gate_state), 32'd0);

    // Wake from OFF: clk_en next cycle, ON after WAKE_CYC, first ack one cycle later.
    idle_thresh = 8'd3;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("wake_clk_en", 32'(clk_en), 32'd1);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("wake_on", 32'(gate_state), 32'd2);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("wake_ack", 32'(ack), 32'd1);

    // Idle close with idle_thresh=3.
    applyStimulus('0, 1'b0);
    checkOutput("close_ack", 32'(ack), 32'd0);
    repeat (3) applyStimulus('0, 1'b0);
    checkOutput("close_drain", 32'(gate_state), 32'd3);
    repeat (2) applyStimulus('0, 1'b0);
    checkOutput("close_clk_en", 32'(clk_en), 32'd0);

    // Drain rescue.
    repeat (5) applyStimulus(4'b0100, 1'b0);
    repeat (4) applyStimulus('0, 1'b0);
    checkOutput("rescue_in_drain", 32'(gate_state), 32'd3);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("rescue_on", 32'(gate_state), 32'd2);
    checkOutput("rescue_clk_en", 32'(clk_en), 32'd1);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("rescue_ack", 32'(ack), 32'd4);

    // Force keeps the gate open without acks; mixed request acked one cycle later.
    repeat (100) applyStimulus('0, 1'b1);
    checkOutput("force_state", 32'(gate_state), 32'd2);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("mixed_ack", 32'(ack), 32'hA);

    // idle_thresh=0 closes the cycle after demand drops.
    idle_thresh = 8'd0;
    applyStimulus('0, 1'b0);
    checkOutput("thresh0_drain", 32'(gate_state), 32'd3);
    repeat (4) applyStimulus('0, 1'b0);
    idle_thresh = 8'd3;

    // Reset mid-WAKE and in ON.
    applyStimulus(4'b0001, 1'b0);
    asyncReset("rst_wake");
    repeat (5) applyStimulus(4'b0011, 1'b0);
    asyncReset("rst_on");

`ifdef PHY_CLK_GATE_CTRL_STATS_EN
    for (int k = 0; k < 3; k++) begin
      repeat (5) applyStimulus(4'b0001, 1'b0);
      repeat (8) applyStimulus('0, 1'b0);
    end
    checkOutput("stats_three", 32'(gate_off_cnt), 32'd3);
`endif

    // Randomized traffic; requests held for runs so both idle close and rescue occur.
    rnd_req = '0;
    rnd_force = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)
        rnd_req = ($urandom_range(0, 1) == 0) ? '0 : NUM_REQ'($urandom);
      if ($urandom_range(0, 39) == 0) rnd_force = ~rnd_force;
      if (modelPhase() == 0 && $urandom_range(0, 9) == 0)
        idle_thresh = CNT_W'($urandom_range(0, 6));
      applyStimulus(rnd_req, rnd_force);
      if ($urandom_range(0, 499) == 0) begin
        asyncReset("rst_rand");
        rnd_req = '0;
        rnd_force = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
